lsu_initiator: RTL

Load/store unit on the pipeline MEM-stage side of the data-memory interface. It accepts one load or store per request from the pipeline and checks alignment, range and overflow. Legal accesses are turned into a req/ack bus transaction with byte enables and a replicated write word. Load data is extracted and sign- or zero-extended, and the pipeline is stalled until each access completes or faults.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_initiator_if.sv | 22 ++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_initiator.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op encodings, FSM states, access sizes
// and the bus timeout/address limit.
package lsu_pkg;

    localparam logic [3:0]  TIMEOUT  = 4'd15;
    localparam logic [31:0] ADDR_MAX = 32'h0000_2fff;

    typedef enum logic [2:0] {
        LSU_LW  = 3'b000,
        LSU_LH  = 3'b001,
        LSU_LHU = 3'b010,
        LSU_LB  = 3'b011,
        LSU_LBU = 3'b100,
        LSU_SW  = 3'b101,
        LSU_SH  = 3'b110,
        LSU_SB  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    function automatic logic is_store(lsu_op_e op);
        return (op == LSU_SW) || (op == LSU_SH) || (op == LSU_SB);
    endfunction

    function automatic lsu_size_e access_size(lsu_op_e op);
        lsu_size_e size;
        case (op)
            LSU_LW, LSU_SW:          size = SZ_WORD;
            LSU_LH, LSU_LHU, LSU_SH: size = SZ_HALF;
            default:                 size = SZ_BYTE;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/lsu_initiator_if.sv
// Req/ack data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_initiator_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational datapath of the load/store unit: fault check, byte-lane steering
// of store data and extraction/extension of load data.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        overflow,
    output logic        fault,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  lsu_op_e     ld_op,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rword,
    output logic [31:0] ld_data
);

    lsu_size_e   size;
    logic [31:0] shifted;
    logic [15:0] half;

    always_comb begin
        size  = access_size(op);
        fault = overflow || (addr > ADDR_MAX);
        case (size)
            SZ_WORD: fault = fault || (addr[1:0] != 2'b00);
            SZ_HALF: fault = fault || addr[0];
            default: ;
        endcase

        case (op)
            LSU_SB: begin
                be        = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            LSU_SH: begin
                be        = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load lane selection works on the access latched at accept time.
    always_comb begin
        shifted = rword >> {ld_offset, 3'b000};
        half    = ld_offset[1] ? rword[31:16] : rword[15:0];
        case (ld_op)
            LSU_LW:  ld_data = rword;
            LSU_LH:  ld_data = {{16{half[15]}}, half};
            LSU_LHU: ld_data = {16'h0000, half};
            LSU_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_LBU: ld_data = {24'h000000, shifted[7:0]};
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_initiator.sv
// MEM-stage load/store unit: IDLE/REQ/DONE handshake FSM with bus timeout.
// Define LSU_TRACE_EN to print a line for every completed store.
module lsu_initiator
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       pc,
    input  logic              overflow,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              AdEL,
    output logic              AdES,
    output logic              bus_err,
    lsu_initiator_if.master   bus
);

    lsu_state_e  state;
    lsu_op_e     op_in;
    lsu_op_e     op_q;
    logic [1:0]  offset_q;
    logic [3:0]  wait_cnt;
    logic        fault;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] ld_data;

    assign op_in = lsu_op_e'(op);
    assign stall = valid && (state != DONE);

    lsu_align u_align (
        .op        (op_in),
        .addr      (addr),
        .wdata     (wdata),
        .overflow  (overflow),
        .fault     (fault),
        .be        (be_next),
        .wdata_rep (wdata_next),
        .ld_op     (op_q),
        .ld_offset (offset_q),
        .rword     (bus.bus_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= LSU_LW;
            offset_q      <= 2'b00;
            wait_cnt      <= 4'd0;
            done          <= 1'b0;
            rdata         <= 32'h0;
            AdEL          <= 1'b0;
            AdES          <= 1'b0;
            bus_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_be    <= 4'h0;
            bus.bus_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        op_q     <= op_in;
                        offset_q <= addr[1:0];
                        if (fault) begin
                            state <= DONE;
                            done  <= 1'b1;
                            rdata <= 32'h0;
                            AdEL  <= !is_store(op_in);
                            AdES  <= is_store(op_in);
                        end else begin
                            state         <= REQ;
                            wait_cnt      <= 4'd0;
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= is_store(op_in);
                            bus.bus_addr  <= {addr[31:2], 2'b00};
                            bus.bus_be    <= be_next;
                            bus.bus_wdata <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        rdata       <= ld_data;
                        bus.bus_req <= 1'b0;
                        bus.bus_we  <= 1'b0;
                    end else if (wait_cnt == TIMEOUT - 4'd1) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        bus_err     <= 1'b1;
                        rdata       <= 32'h0;
                        bus.bus_req <= 1'b0;
                        bus.bus_we  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    rdata   <= 32'h0;
                    AdEL    <= 1'b0;
                    AdES    <= 1'b0;
                    bus_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_TRACE_EN
    logic [31:0] pc_q;
    logic [31:0] lane_mask;

    assign lane_mask = {{8{bus.bus_be[3]}}, {8{bus.bus_be[2]}},
                        {8{bus.bus_be[1]}}, {8{bus.bus_be[0]}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'h0;
        end else if (state == IDLE && valid) begin
            pc_q <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == REQ && bus.bus_ack && bus.bus_we) begin
            $display("@%h: *%h <= %h", pc_q, bus.bus_addr, bus.bus_wdata & lane_mask);
        end
    end
`else
    // The PC only feeds the store trace.
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule
